// File: rtl/sim_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_mon_pkg
// Description : Shared types, status constants and helpers for the simulation
//               cycle/retirement monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_mon_pkg;

    // Widest commit bundle the monitor supports, and the popcount result width
    localparam int c_MAX_COMMIT = 8;
    localparam int c_POP_W      = 4;
    localparam int c_STATE_W    = 3;

    // Monitor FSM states; the encoding is visible on the state output
    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_HUNG    = 3'd4,
        ST_TIMEOUT = 3'd5
    } sim_mon_state_t;

    // Raw status encodings for environments that compare the state bus numerically
    localparam logic [c_STATE_W-1:0] c_STATUS_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_STATUS_RUN     = 3'd1;
    localparam logic [c_STATE_W-1:0] c_STATUS_DRAIN   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_STATUS_DONE    = 3'd3;
    localparam logic [c_STATE_W-1:0] c_STATUS_HUNG    = 3'd4;
    localparam logic [c_STATE_W-1:0] c_STATUS_TIMEOUT = 3'd5;

    // Number of set bits; narrower commit bundles are zero-extended by the caller
    function automatic logic [c_POP_W-1:0] popcount(input logic [c_MAX_COMMIT-1:0] v);
        logic [c_POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_COMMIT; i++) begin
            cnt = cnt + c_POP_W'(v[i]);
        end
        return cnt;
    endfunction

    // True for the states that end a simulation run
    function automatic logic is_terminal(input sim_mon_state_t s);
        return (s == ST_DONE) || (s == ST_HUNG) || (s == ST_TIMEOUT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear and a variable increment
//               that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   w_sum;

    // Next value: clear wins, otherwise add with one guard bit and clamp on carry-out
    always_comb begin
        w_sum   = {1'b0, count_q} + (WIDTH+1)'(inc_i);
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (w_sum[WIDTH]) begin
                count_d = '1;
            end else begin
                count_d = w_sum[WIDTH-1:0];
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sim_cycle_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sim_cycle_monitor
// Description : Counts cycles, retired instructions and stall cycles across
//               the commit channels and decides when simulation ends: clean
//               halt+drain, deadlock (no commits too long) or cycle cap.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_cycle_monitor
    import sim_mon_pkg::*;
#(
    parameter int CYCLE_W      = 32,
    parameter int RETIRE_W     = 32,
    parameter int COMMIT_WIDTH = 2,
    parameter int IDLE_LIMIT   = 16,
    parameter int MAX_CYCLES   = 10000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [COMMIT_WIDTH-1:0] commit_valid_i,
    input  logic                    halt_req_i,
    output logic [2:0]              state_o,
    output logic [CYCLE_W-1:0]      cycle_count_o,
    output logic [RETIRE_W-1:0]     retire_count_o,
    output logic [CYCLE_W-1:0]      stall_count_o,
    output logic                    done_o,
    output logic                    pass_o
);

    // idle_cnt must be able to hold IDLE_LIMIT itself (its saturation point)
    localparam int                  c_IDLE_W       = $clog2(IDLE_LIMIT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX     = c_IDLE_W'(IDLE_LIMIT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST    = c_IDLE_W'(IDLE_LIMIT - 1);
    localparam logic [CYCLE_W-1:0]  c_CYCLE_LAST   = CYCLE_W'(MAX_CYCLES - 1);

    sim_mon_state_t          state_q, state_d;
    logic [c_IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;

    logic [c_MAX_COMMIT-1:0] w_commit_ext;
    logic [c_POP_W-1:0]      w_pop;
    logic                    w_any_commit;
    logic                    w_active;
    logic                    w_clr;
    logic                    w_timeout_hit;
    logic                    w_idle_hit;

    // Commit bookkeeping shared by the counters and the FSM
    always_comb begin
        w_commit_ext                 = '0;
        w_commit_ext[COMMIT_WIDTH-1:0] = commit_valid_i;
        w_pop         = popcount(w_commit_ext);
        w_any_commit  = |commit_valid_i;
        w_active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        // start is only honoured outside RUN/DRAIN; accepting it wipes the counters
        w_clr         = start_i && !w_active;
        w_timeout_hit = (cycle_count_o == c_CYCLE_LAST);
        w_idle_hit    = (idle_cnt_q == c_IDLE_LAST) && !w_any_commit;
    end

    sat_counter #(
        .WIDTH (CYCLE_W),
        .INC_W (1)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_clr),
        .en_i    (w_active),
        .inc_i   (1'b1),
        .count_o (cycle_count_o)
    );

    sat_counter #(
        .WIDTH (RETIRE_W),
        .INC_W (c_POP_W)
    ) u_retire_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_clr),
        .en_i    (w_active),
        .inc_i   (w_pop),
        .count_o (retire_count_o)
    );

    sat_counter #(
        .WIDTH (CYCLE_W),
        .INC_W (1)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_clr),
        .en_i    (w_active && !w_any_commit),
        .inc_i   (1'b1),
        .count_o (stall_count_o)
    );

    // Next state and idle-run length; timeout outranks halt, halt outranks hung
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;

        if (w_clr) begin
            idle_cnt_d = '0;
        end else if (w_active) begin
            if (w_any_commit) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q != c_IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + c_IDLE_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_timeout_hit)   state_d = ST_TIMEOUT;
                else if (halt_req_i) state_d = ST_DRAIN;
                else if (w_idle_hit) state_d = ST_HUNG;
            end
            ST_DRAIN: begin
                if (w_timeout_hit)   state_d = ST_TIMEOUT;
                else if (w_idle_hit) state_d = ST_DONE;
            end
            ST_DONE, ST_HUNG, ST_TIMEOUT: begin
                if (start_i) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and idle-run registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign state_o = state_q;
    assign done_o  = is_terminal(state_q);
    assign pass_o  = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sim_cycle_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_cycle_monitor
// Description : Directed self-checking bench for sim_cycle_monitor.
//               dut     : COMMIT_WIDTH=2, IDLE_LIMIT=4, MAX_CYCLES=20
//               dut_sat : same, with RETIRE_W=4 for saturation
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_cycle_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cv;
    logic        halt;

    logic [2:0]  st;
    logic [31:0] cyc, ret, stl;
    logic        dn, ps;

    logic [2:0]  st2;
    logic [31:0] cyc2, stl2;
    logic [3:0]  ret2;
    logic        dn2, ps2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sim_cycle_monitor #(
        .CYCLE_W(32), .RETIRE_W(32), .COMMIT_WIDTH(2), .IDLE_LIMIT(4), .MAX_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .commit_valid_i(cv), .halt_req_i(halt),
        .state_o(st), .cycle_count_o(cyc), .retire_count_o(ret), .stall_count_o(stl),
        .done_o(dn), .pass_o(ps)
    );

    sim_cycle_monitor #(
        .CYCLE_W(32), .RETIRE_W(4), .COMMIT_WIDTH(2), .IDLE_LIMIT(4), .MAX_CYCLES(20)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_i(start), .commit_valid_i(cv), .halt_req_i(halt),
        .state_o(st2), .cycle_count_o(cyc2), .retire_count_o(ret2), .stall_count_o(stl2),
        .done_o(dn2), .pass_o(ps2)
    );

    // One clock with the given inputs; outputs are sampled 1ns after the edge
    task automatic step(input logic s, input logic [1:0] v, input logic h);
        start = s; cv = v; halt = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; cv = 2'b00; halt = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; cv = 2'b00; halt = 1'b0;
        #2 rst_n = 1'b0;
        #12;
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st); end
        checks++; if (cyc !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d want 0", cyc); end
        checks++; if (ret !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", ret); end
        checks++; if (stl !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stl); end
        checks++; if (dn !== 1'b0 || ps !== 1'b0) begin errors++; $display("FAIL reset_done_pass got %b%b want 00", dn, ps); end
        rst_n = 1'b1;
        step(1'b0, 2'b11, 1'b0);
        checks++; if (st !== 3'd0 || ret !== 32'd0) begin errors++; $display("FAIL idle_no_count got st=%0d ret=%0d want 0/0", st, ret); end
    endtask

    task automatic test_normal_halt();
        step(1'b1, 2'b11, 1'b0);
        checks++; if (st !== 3'd1 || ret !== 32'd0 || cyc !== 32'd0) begin errors++; $display("FAIL start_run got st=%0d cyc=%0d ret=%0d want 1/0/0", st, cyc, ret); end
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 1'b0);
        step(1'b0, 2'b01, 1'b1);
        checks++; if (st !== 3'd2 || ret !== 32'd21 || cyc !== 32'd11) begin errors++; $display("FAIL halt_drain got st=%0d cyc=%0d ret=%0d want 2/11/21", st, cyc, ret); end
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
        checks++; if (st !== 3'd2) begin errors++; $display("FAIL drain_hold got %0d want 2", st); end
        step(1'b0, 2'b00, 1'b0);
        checks++; if (st !== 3'd3 || ps !== 1'b1 || dn !== 1'b1) begin errors++; $display("FAIL done_state got st=%0d done=%b pass=%b want 3/1/1", st, dn, ps); end
        checks++; if (cyc !== 32'd15 || ret !== 32'd21 || stl !== 32'd4) begin errors++; $display("FAIL done_counts got cyc=%0d ret=%0d stl=%0d want 15/21/4", cyc, ret, stl); end
        step(1'b0, 2'b11, 1'b1);
        checks++; if (st !== 3'd3 || cyc !== 32'd15 || ret !== 32'd21) begin errors++; $display("FAIL done_hold got st=%0d cyc=%0d ret=%0d want 3/15/21", st, cyc, ret); end
    endtask

    task automatic test_rearm();
        step(1'b1, 2'b11, 1'b0);
        checks++; if (st !== 3'd1 || cyc !== 32'd0 || ret !== 32'd0 || stl !== 32'd0) begin errors++; $display("FAIL rearm got st=%0d cyc=%0d ret=%0d stl=%0d want 1/0/0/0", st, cyc, ret, stl); end
        step(1'b1, 2'b11, 1'b0);
        checks++; if (st !== 3'd1 || cyc !== 32'd1 || ret !== 32'd2) begin errors++; $display("FAIL start_in_run got st=%0d cyc=%0d ret=%0d want 1/1/2", st, cyc, ret); end
    endtask

    task automatic test_drain_short();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        checks++; if (st !== 3'd2) begin errors++; $display("FAIL short_drain_hold got %0d want 2", st); end
        step(1'b0, 2'b00, 1'b0);
        checks++; if (st !== 3'd3 || cyc !== 32'd6 || stl !== 32'd4 || ret !== 32'd2) begin errors++; $display("FAIL short_drain_done got st=%0d cyc=%0d stl=%0d ret=%0d want 3/6/4/2", st, cyc, stl, ret); end
    endtask

    task automatic test_deadlock();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
        checks++; if (st !== 3'd1) begin errors++; $display("FAIL pre_hung got %0d want 1", st); end
        step(1'b0, 2'b00, 1'b0);
        checks++; if (st !== 3'd4 || dn !== 1'b1 || ps !== 1'b0) begin errors++; $display("FAIL hung_state got st=%0d done=%b pass=%b want 4/1/0", st, dn, ps); end
        checks++; if (cyc !== 32'd7 || ret !== 32'd3 || stl !== 32'd4) begin errors++; $display("FAIL hung_counts got cyc=%0d ret=%0d stl=%0d want 7/3/4", cyc, ret, stl); end
    endtask

    task automatic test_halt_beats_hung();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        checks++; if (st !== 3'd2) begin errors++; $display("FAIL halt_vs_hung got %0d want 2", st); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b0, 2'b01, 1'b0);
        checks++; if (st !== 3'd1 || cyc !== 32'd19) begin errors++; $display("FAIL pre_timeout got st=%0d cyc=%0d want 1/19", st, cyc); end
        step(1'b0, 2'b01, 1'b0);
        checks++; if (st !== 3'd5 || cyc !== 32'd20 || ret !== 32'd20 || dn !== 1'b1 || ps !== 1'b0) begin errors++; $display("FAIL timeout got st=%0d cyc=%0d ret=%0d done=%b pass=%b want 5/20/20/1/0", st, cyc, ret, dn, ps); end
        step(1'b0, 2'b11, 1'b1);
        checks++; if (st !== 3'd5 || cyc !== 32'd20 || ret !== 32'd20) begin errors++; $display("FAIL timeout_hold got st=%0d cyc=%0d ret=%0d want 5/20/20", st, cyc, ret); end
    endtask

    task automatic test_timeout_vs_halt();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        checks++; if (st !== 3'd5 || cyc !== 32'd20 || ret !== 32'd19 || stl !== 32'd1) begin errors++; $display("FAIL timeout_vs_halt got st=%0d cyc=%0d ret=%0d stl=%0d want 5/20/19/1", st, cyc, ret, stl); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b11, 1'b0);
        checks++; if (ret !== 32'd10 || cyc !== 32'd5) begin errors++; $display("FAIL pre_reset got cyc=%0d ret=%0d want 5/10", cyc, ret); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (st !== 3'd0 || cyc !== 32'd0 || ret !== 32'd0 || stl !== 32'd0) begin errors++; $display("FAIL async_reset got st=%0d cyc=%0d ret=%0d stl=%0d want 0/0/0/0", st, cyc, ret, stl); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 1'b1);
        checks++; if (st !== 3'd0 || cyc !== 32'd0 || ret !== 32'd0) begin errors++; $display("FAIL post_reset_idle got st=%0d cyc=%0d ret=%0d want 0/0/0", st, cyc, ret); end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 2'b11, 1'b0);
        checks++; if (ret2 !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d want 14", ret2); end
        step(1'b0, 2'b11, 1'b0);
        checks++; if (ret2 !== 4'd15) begin errors++; $display("FAIL sat_clamp got %0d want 15", ret2); end
        step(1'b0, 2'b11, 1'b0);
        checks++; if (ret2 !== 4'd15 || ret !== 32'd18) begin errors++; $display("FAIL sat_nowrap got narrow=%0d wide=%0d want 15/18", ret2, ret); end
    endtask

    initial begin
        test_reset();
        test_normal_halt();
        test_rearm();
        test_drain_short();
        test_deadlock();
        test_halt_beats_hung();
        test_timeout();
        test_timeout_vs_halt();
        test_reset_mid_run();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
